// File: rtl/paddle_motion_ctrl.sv
// rtl/paddle_motion_ctrl.sv - frame-synchronous paddle position with press/hold auto-repeat; optional macro PADDLE_ACCEL_EN
module paddle_motion_ctrl #(
  parameter int SCREEN_H     = 600,
  parameter int PADDLE_H     = 64,
  parameter int START_Y      = 268,
  parameter int STEP         = 4,
  parameter int REPEAT_DELAY = 15,
  parameter bit VSYNC_POL    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       up,
  input  logic       down,
  input  logic [2:0] stateGame,
  output logic [9:0] paddle_y,
  output logic       moving,
  output logic       hit_top,
  output logic       hit_bottom,
  output logic       frame_tick
);

  localparam int         MAX_Y    = SCREEN_H - PADDLE_H;
  localparam logic [2:0] GS_IDLE  = 3'd0;
  localparam logic [2:0] GS_PLAY  = 3'd1;
  localparam logic [2:0] GS_RESET = 3'd3;

  typedef enum logic [1:0] {M_IDLE, M_DELAY, M_REPEAT} motion_t;

  motion_t    state;
  logic [5:0] repeat_cnt;
  logic       latched_up;

  logic vsync_meta, vsync_sync, vsync_prev;
  logic sync_live, tick_armed;

  logic dir_up, dir_dn, dir_any, held;
  logic restart, advance, press_new, hold_rep, move_req, move_up;
  logic [10:0] cur_y11, step11, sum11;
  logic [9:0]  next_y;

`ifdef PADDLE_ACCEL_EN
  logic [2:0] accel_cnt;
  logic [1:0] accel_lvl;
`endif

  // Synchronise vsync and pulse frame_tick on its leading edge; a level already
  // active when reset releases must go inactive once before it can tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_meta <= ~VSYNC_POL;
      vsync_sync <= ~VSYNC_POL;
      vsync_prev <= ~VSYNC_POL;
      sync_live  <= 1'b0;
      tick_armed <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vsync_meta <= vsync;
      vsync_sync <= vsync_meta;
      vsync_prev <= vsync_sync;
      sync_live  <= 1'b1;
      if (sync_live && (vsync_meta != VSYNC_POL))
        tick_armed <= 1'b1;
      frame_tick <= tick_armed && (vsync_sync == VSYNC_POL) && (vsync_prev != VSYNC_POL);
    end
  end

  assign dir_up    = up & ~down;
  assign dir_dn    = down & ~up;
  assign dir_any   = dir_up | dir_dn;
  assign held      = dir_any && (dir_up == latched_up);
  assign restart   = (stateGame == GS_IDLE) || (stateGame == GS_RESET);
  assign advance   = frame_tick && (stateGame == GS_PLAY);
  assign press_new = dir_any && ((state == M_IDLE) || !held);
  assign hold_rep  = (state == M_REPEAT) && held;
  assign move_req  = press_new | hold_rep;
  assign move_up   = press_new ? dir_up : latched_up;

  // Candidate position for this frame, clamped to the visible range
  always_comb begin
    cur_y11 = {1'b0, paddle_y};
`ifdef PADDLE_ACCEL_EN
    step11 = press_new ? 11'(STEP) : (11'(STEP) << accel_lvl);
`else
    step11 = 11'(STEP);
`endif
    sum11  = cur_y11 + step11;
    next_y = paddle_y;
    if (move_req) begin
      if (move_up)
        next_y = (cur_y11 < step11) ? 10'd0 : 10'(cur_y11 - step11);
      else
        next_y = (sum11 > 11'(MAX_Y)) ? 10'(MAX_Y) : 10'(sum11);
    end
  end

  // Motion FSM and position registers; only PLAY frame ticks advance them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= M_IDLE;
      repeat_cnt <= 6'd0;
      latched_up <= 1'b0;
      paddle_y   <= 10'(START_Y);
      moving     <= 1'b0;
      hit_top    <= 1'b0;
      hit_bottom <= 1'b0;
    end else if (restart) begin
      state      <= M_IDLE;
      repeat_cnt <= 6'd0;
      paddle_y   <= 10'(START_Y);
      moving     <= 1'b0;
      hit_top    <= (START_Y == 0);
      hit_bottom <= (START_Y == MAX_Y);
    end else begin
      moving <= 1'b0;
      if (advance) begin
        paddle_y   <= next_y;
        moving     <= (next_y != paddle_y);
        hit_top    <= (next_y == 10'd0);
        hit_bottom <= (next_y == 10'(MAX_Y));
        if (press_new) begin
          state      <= M_DELAY;
          repeat_cnt <= 6'(REPEAT_DELAY);
          latched_up <= dir_up;
        end else if (!dir_any) begin
          state      <= M_IDLE;
          repeat_cnt <= 6'd0;
        end else if (state == M_DELAY) begin
          repeat_cnt <= repeat_cnt - 6'd1;
          if (repeat_cnt == 6'd1)
            state <= M_REPEAT;
        end
      end
    end
  end

`ifdef PADDLE_ACCEL_EN
  // Count repeat frames; every eighth one doubles the step, up to 4x
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accel_cnt <= 3'd0;
      accel_lvl <= 2'd0;
    end else if (restart) begin
      accel_cnt <= 3'd0;
      accel_lvl <= 2'd0;
    end else if (advance) begin
      if (hold_rep) begin
        accel_cnt <= accel_cnt + 3'd1;
        if ((accel_cnt == 3'd7) && (accel_lvl != 2'd2))
          accel_lvl <= accel_lvl + 2'd1;
      end else begin
        accel_cnt <= 3'd0;
        accel_lvl <= 2'd0;
      end
    end
  end
`endif

endmodule
